// File: rtl/tdm_demux_1xn_if.sv
// Bus bundle for the 1-to-2**N TDM demultiplexer: serial input side plus the
// recovered parallel frame, strobes and lock/slot status.
interface tdm_demux_1xn_if #(
    parameter int unsigned N = 3
);
    localparam int unsigned LANES = 2 ** N;

    logic             din;
    logic             din_valid;
    logic             frame_sync;
    logic [0:LANES-1] out;
    logic             frame_valid;
    logic             frame_err;
    logic [N-1:0]     sel_o;
    logic             locked;

    // Link side: drives the serial stream, observes the recovered frame.
    modport master (
        output din,
        output din_valid,
        output frame_sync,
        input  out,
        input  frame_valid,
        input  frame_err,
        input  sel_o,
        input  locked
    );

    // Demux side.
    modport slave (
        input  din,
        input  din_valid,
        input  frame_sync,
        output out,
        output frame_valid,
        output frame_err,
        output sel_o,
        output locked
    );
endinterface

// File: rtl/tdm_demux_1xn.sv
// Sequential 1-to-2**N TDM demultiplexer. Serial slot bits are collected into a
// shadow frame; on the last slot the full frame is published to out with a
// one-cycle frame_valid pulse. A sync arriving mid-frame drops the partial frame,
// raises frame_err for one cycle and restarts at slot 0 with that bit.
module tdm_demux_1xn #(
    parameter int unsigned N = 3
) (
    input logic            clk,
    input logic            rst_n,
    tdm_demux_1xn_if.slave bus
);
    localparam int unsigned LANES = 2 ** N;

    typedef enum logic {
        StIdle,
        StRecv
    } state_e;

    state_e           state_q;
    logic [0:LANES-1] shadow_q;
    logic [0:LANES-1] out_q;
    logic [N-1:0]     sel_q;
    logic             frame_valid_q;
    logic             frame_err_q;
    logic             locked_q;

    // Slot pointer at the last lane: all ones since LANES is a power of two.
    logic last_slot;
    assign last_slot = &sel_q;

    // Single FSM: all outputs are registered, pulses default low every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            shadow_q      <= '0;
            out_q         <= '0;
            sel_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            if (bus.din_valid) begin
                unique case (state_q)
                    StIdle: begin
                        if (bus.frame_sync) begin
                            shadow_q[0] <= bus.din;
                            sel_q       <= N'(1);
                            state_q     <= StRecv;
                            locked_q    <= 1'b1;
                        end
                    end
                    StRecv: begin
                        if (bus.frame_sync && (sel_q != '0)) begin
                            // Misplaced sync: realign, this bit becomes slot 0.
                            frame_err_q <= 1'b1;
                            shadow_q[0] <= bus.din;
                            sel_q       <= N'(1);
                        end else begin
                            shadow_q[sel_q] <= bus.din;
                            sel_q           <= sel_q + N'(1);
                            if (last_slot) begin
                                // Publish with the live bit; shadow's last lane isn't written yet.
                                out_q         <= {shadow_q[0:LANES-2], bus.din};
                                frame_valid_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q  <= StIdle;
                        sel_q    <= '0;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Drive the bus from the registered state.
    always_comb begin
        bus.out         = out_q;
        bus.frame_valid = frame_valid_q;
        bus.frame_err   = frame_err_q;
        bus.sel_o       = sel_q;
        bus.locked      = locked_q;
    end
endmodule

// File: tb/tb_tdm_demux_1xn.sv
// Directed bench for tdm_demux_1xn (N=3): a behavioural model predicts slot
// pointer, strobes and frames; published frames are queued and popped by a
// monitor whenever the DUT pulses frame_valid.
module tb_tdm_demux_1xn;
    localparam int unsigned N     = 3;
    localparam int unsigned LANES = 2 ** N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    tdm_demux_1xn_if #(.N(N)) bus ();

    tdm_demux_1xn #(.N(N)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state.
    logic             m_locked;
    int               m_sel;
    logic [0:LANES-1] m_sh;
    logic [0:LANES-1] m_out;
    logic             exp_fv;
    logic             exp_fe;
    logic [0:LANES-1] frame_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_sel    = 0;
        m_sh     = '0;
        m_out    = '0;
        exp_fv   = 1'b0;
        exp_fe   = 1'b0;
        frame_q.delete();
    endtask

    task automatic model_beat(input logic d, input logic s);
        exp_fv = 1'b0;
        exp_fe = 1'b0;
        if (!m_locked) begin
            if (s) begin
                m_sh[0]  = d;
                m_sel    = 1;
                m_locked = 1'b1;
            end
        end else if (s && m_sel != 0) begin
            exp_fe  = 1'b1;
            m_sh[0] = d;
            m_sel   = 1;
        end else begin
            m_sh[m_sel] = d;
            if (m_sel == LANES - 1) begin
                m_out  = m_sh;
                exp_fv = 1'b1;
                frame_q.push_back(m_sh);
            end
            m_sel = (m_sel + 1) % LANES;
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".frame_valid"}, 32'(bus.frame_valid), 32'(exp_fv));
        chk({tag, ".frame_err"}, 32'(bus.frame_err), 32'(exp_fe));
        chk({tag, ".sel_o"}, 32'(bus.sel_o), 32'(m_sel));
        chk({tag, ".locked"}, 32'(bus.locked), 32'(m_locked));
        chk({tag, ".out"}, 32'(bus.out), 32'(m_out));
    endtask

    // One valid beat; inputs drop after the edge so a following beat call is gapless.
    task automatic beat(input logic d, input logic s, input string tag);
        bus.din        = d;
        bus.din_valid  = 1'b1;
        bus.frame_sync = s;
        model_beat(d, s);
        @(posedge clk);
        #1;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
        check_status(tag);
    endtask

    task automatic idle(input int n, input string tag);
        bus.din_valid = 1'b0;
        exp_fv        = 1'b0;
        exp_fe        = 1'b0;
        repeat (n) begin
            bus.din = ~bus.din;
            @(posedge clk);
            #1;
            check_status(tag);
        end
    endtask

    task automatic send_frame(input logic [0:LANES-1] f, input logic sync, input int gap,
                              input string tag);
        for (int i = 0; i < LANES; i++) begin
            beat(f[i], sync && (i == 0), tag);
            if (gap > 0 && i < LANES - 1) idle(gap, tag);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_status("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard: pop one expected frame per frame_valid pulse.
    always @(negedge clk) begin
        if (rst_n && bus.frame_valid) begin
            if (frame_q.size() == 0) begin
                chk("sb.unexpected_frame", 32'(bus.out), 32'hffff_ffff);
            end else begin
                chk("sb.frame", 32'(bus.out), 32'(frame_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:LANES-1] f;
        bus.din        = 1'b0;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
        model_reset();

        // Reset state.
        #1;
        check_status("reset0");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Bits without sync while idle are ignored.
        f = 8'b1101_0110;
        send_frame(f, 1'b0, 0, "nosync");
        chk("nosync.locked", 32'(bus.locked), 32'd0);

        // First synced frame.
        f = 8'b1010_1100;
        send_frame(f, 1'b1, 0, "frame1");
        chk("frame1.out_const", 32'(bus.out), 32'h0000_00ac);
        chk("frame1.locked", 32'(bus.locked), 32'd1);
        idle(2, "frame1.hold");

        // Back-to-back frames, second without sync.
        f = 8'b1010_1100;
        send_frame(f, 1'b1, 0, "b2b.a");
        f = 8'b0101_0011;
        send_frame(f, 1'b0, 0, "b2b.b");
        chk("b2b.out_const", 32'(bus.out), 32'h0000_0053);

        // Sync at slot 5: error, realign, complete frame.
        f = 8'b1110_0000;
        for (int i = 0; i < 5; i++) beat(f[i], i == 0, "err.pre");
        beat(1'b1, 1'b1, "err.sync5");
        chk("err.pulse", 32'(bus.frame_err), 32'd1);
        chk("err.out_kept", 32'(bus.out), 32'h0000_0053);
        chk("err.sel", 32'(bus.sel_o), 32'd1);
        f = 8'b1011_0101;
        for (int i = 1; i < LANES; i++) beat(f[i], 1'b0, "err.rest");
        chk("err.out_const", 32'(bus.out), 32'h0000_00b5);

        // Gaps of two idle cycles between beats.
        f = 8'b0110_1001;
        send_frame(f, 1'b0, 2, "gaps");
        chk("gaps.out_const", 32'(bus.out), 32'h0000_0069);

        // Reset at slot 4, then a clean frame.
        f = 8'b1111_0000;
        for (int i = 0; i < 4; i++) beat(f[i], i == 0, "rst.pre");
        apply_reset();
        chk("rst.out_zero", 32'(bus.out), 32'd0);
        f = 8'b1001_1010;
        send_frame(f, 1'b1, 0, "rst.post");
        chk("rst.out_const", 32'(bus.out), 32'h0000_009a);

        idle(2, "tail");
        chk("sb.drained", 32'(frame_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
